// File: rtl/apb4_reg_bridge.sv
// APB4 completer bridging to the regblock bus_req/bus_ready handshake.
// Optional bus-timeout enabled by defining APB4_BRIDGE_TIMEOUT_EN.
module apb4_reg_bridge #(
   parameter int PADDR_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter logic [PADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [PADDR_WIDTH-1:0]  paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    pready,
   output logic                    pslverr,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    bus_req,
   output logic                    bus_req_is_wr,
   output logic [ADDR_WIDTH-1:0]   bus_addr,
   output logic [DATA_WIDTH-1:0]   bus_wr_data,
   output logic [DATA_WIDTH-1:0]   bus_wr_biten,
   input  logic                    bus_req_stall_wr,
   input  logic                    bus_req_stall_rd,
   input  logic                    bus_ready,
   input  logic                    bus_err,
   input  logic [DATA_WIDTH-1:0]   bus_rd_data
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int AB = $clog2(SW);
   localparam logic [PADDR_WIDTH-1:0] ALIGN_MASK =
      PADDR_WIDTH'((1 << AB) - 1);

   if (DATA_WIDTH != 8 && DATA_WIDTH != 16 &&
       DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_dw_chk
      $error("DATA_WIDTH must be 8, 16, 32 or 64");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_to_chk
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_nx;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_nx;
   logic [SW-1:0]         strb_q, strb_nx;
   logic                  wr_q, wr_nx;
   logic                  err_q, err_nx;
   logic                  miss, stall, go, take;
   logic [DATA_WIDTH-1:0] biten;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         strb_q  <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         addr_q  <= addr_nx;
         wdata_q <= wdata_nx;
         rdata_q <= rdata_nx;
         strb_q  <= strb_nx;
         wr_q    <= wr_nx;
         err_q   <= err_nx;
      end
   end

`ifdef APB4_BRIDGE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
   logic          expired;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tcnt <= '0;
      else if (state == IDLE)
         tcnt <= '0;
      else if (state == REQ || state == WAIT)
         tcnt <= tcnt + 1'b1;
   end

   assign expired = (state == REQ || state == WAIT) && !take &&
                    (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
   logic expired;
   assign expired = 1'b0;
`endif

   assign miss = (paddr[PADDR_WIDTH-1:ADDR_WIDTH] !=
                  BASE_ADDR[PADDR_WIDTH-1:ADDR_WIDTH]) ||
                 (|(paddr & ALIGN_MASK));
   assign stall = wr_q ? bus_req_stall_wr : bus_req_stall_rd;
   assign go    = (state == REQ) && !stall;
   assign take  = (go || state == WAIT) && bus_ready;

   always_comb begin
      state_nx = state;
      addr_nx  = addr_q;
      wdata_nx = wdata_q;
      rdata_nx = rdata_q;
      strb_nx  = strb_q;
      wr_nx    = wr_q;
      err_nx   = err_q;
      unique case (state)
         IDLE: begin
            if (psel && !penable) begin
               addr_nx  = paddr[ADDR_WIDTH-1:0];
               wdata_nx = pwdata;
               strb_nx  = pstrb;
               wr_nx    = pwrite;
               rdata_nx = '0;
               err_nx   = miss;
               // zero-strobe writes complete as a no-op
               if (miss || (pwrite && pstrb == '0))
                  state_nx = RESP;
               else
                  state_nx = REQ;
            end
         end
         REQ: begin
            if (go)
               state_nx = bus_ready ? RESP : WAIT;
         end
         WAIT: begin
            if (bus_ready)
               state_nx = RESP;
         end
         RESP: state_nx = IDLE;
      endcase
      if (take) begin
         rdata_nx = wr_q ? '0 : bus_rd_data;
         err_nx   = bus_err;
      end
      if (expired) begin
         state_nx = RESP;
         rdata_nx = '0;
         err_nx   = 1'b1;
      end
   end

   always_comb begin
      biten = '0;
      for (int i = 0; i < SW; i++)
         biten[i*8 +: 8] = {8{strb_q[i]}};
   end

   assign pready        = (state == RESP);
   assign prdata        = pready ? rdata_q : '0;
   assign pslverr       = pready & err_q;
   assign bus_req       = go;
   assign bus_req_is_wr = go & wr_q;
   assign bus_addr      = go ? addr_q : '0;
   assign bus_wr_data   = go ? wdata_q : '0;
   assign bus_wr_biten  = (go && wr_q) ? biten : '0;

endmodule

// File: tb/tb_apb4_reg_bridge.sv
// Scoreboard bench for apb4_reg_bridge: directed APB transfers,
// expected bus requests and APB responses checked by a monitor.
module tb_apb4_reg_bridge;

   localparam logic [31:0] BASE = 32'h4000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic        pready, pslverr;
   logic [31:0] prdata;
   logic        bus_req, bus_req_is_wr;
   logic [7:0]  bus_addr;
   logic [31:0] bus_wr_data, bus_wr_biten;
   logic        bus_req_stall_wr = 1'b0, bus_req_stall_rd = 1'b0;
   logic        bus_ready = 1'b0, bus_err = 1'b0;
   logic [31:0] bus_rd_data = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] biten;
   } req_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];

   apb4_reg_bridge #(
      .PADDR_WIDTH(32),
      .ADDR_WIDTH(8),
      .DATA_WIDTH(32),
      .BASE_ADDR(BASE),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .psel(psel),
      .penable(penable),
      .pwrite(pwrite),
      .paddr(paddr),
      .pwdata(pwdata),
      .pstrb(pstrb),
      .pready(pready),
      .pslverr(pslverr),
      .prdata(prdata),
      .bus_req(bus_req),
      .bus_req_is_wr(bus_req_is_wr),
      .bus_addr(bus_addr),
      .bus_wr_data(bus_wr_data),
      .bus_wr_biten(bus_wr_biten),
      .bus_req_stall_wr(bus_req_stall_wr),
      .bus_req_stall_rd(bus_req_stall_rd),
      .bus_ready(bus_ready),
      .bus_err(bus_err),
      .bus_rd_data(bus_rd_data)
   );

   always #5 clk = ~clk;

   // monitor: outputs sampled on the falling edge
   always @(negedge clk) begin
      req_t e;
      rsp_t r;
      if (!rst) begin
         cyc++;
         if (psel && !penable) t0 = cyc;
         checks++;
         if (bus_req) begin
            if (req_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_bus_req addr=%h got req, required none",
                        bus_addr);
            end else begin
               e = req_q.pop_front();
               if (bus_req_is_wr !== e.wr || bus_addr !== e.addr ||
                   bus_wr_data !== e.wdata || bus_wr_biten !== e.biten) begin
                  errors++;
                  $display("FAIL bus_req got wr=%b a=%h d=%h be=%h required wr=%b a=%h d=%h be=%h",
                           bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
                           e.wr, e.addr, e.wdata, e.biten);
               end
            end
         end else if (bus_req_is_wr || bus_addr != 0 || bus_wr_data != 0 ||
                      bus_wr_biten != 0) begin
            errors++;
            $display("FAIL bus_idle got wr=%b a=%h d=%h be=%h required all 0",
                     bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten);
         end
         checks++;
         if (pready) begin
            if (rsp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pready got 1 required 0");
            end else begin
               r = rsp_q.pop_front();
               if (prdata !== r.rdata || pslverr !== r.err ||
                   (cyc - t0) != r.lat) begin
                  errors++;
                  $display("FAIL apb_rsp got d=%h err=%b lat=%0d required d=%h err=%b lat=%0d",
                           prdata, pslverr, cyc - t0, r.rdata, r.err, r.lat);
               end
            end
         end else if (prdata !== 32'h0 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL apb_idle got d=%h err=%b required 0/0", prdata, pslverr);
         end
      end
   end

   task automatic bus_clr();
      bus_req_stall_rd = 1'b0;
      bus_req_stall_wr = 1'b0;
      bus_ready = 1'b0;
      bus_err = 1'b0;
      bus_rd_data = '0;
   endtask

   // srd/swr: stall cycles; rdly: ready cycles after accept (-1 none)
   task automatic xfer(input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input int srd, input int swr, input int rdly,
                       input logic [31:0] rdat, input bit berr,
                       input bit exp_req, input logic [31:0] exp_be,
                       input logic [31:0] exp_d, input bit exp_err,
                       input int exp_lat);
      int  reqk;
      bit  done;
      req_t e;
      rsp_t r;
      done = 1'b0;
      reqk = 1 + (wr ? swr : srd);
      if (exp_req) begin
         e.wr = wr; e.addr = addr[7:0]; e.wdata = wdata; e.biten = exp_be;
         req_q.push_back(e);
      end
      r.rdata = exp_d; r.err = exp_err; r.lat = exp_lat;
      rsp_q.push_back(r);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr;
      paddr = addr; pwdata = wdata; pstrb = strb;
      bus_clr();
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         penable = 1'b1;
         bus_req_stall_rd = (k <= srd);
         bus_req_stall_wr = (k <= swr);
         bus_ready = (rdly >= 0) && (k == reqk + rdly);
         bus_rd_data = bus_ready ? rdat : '0;
         bus_err = bus_ready && berr;
         @(negedge clk);
         if (pready) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL xfer_timeout addr=%h got no pready required pready", addr);
         void'(rsp_q.pop_back());
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      bus_clr();
   endtask

   task automatic chk_zero(input string name);
      checks++;
      if (pready || pslverr || prdata != 0 || bus_req || bus_req_is_wr ||
          bus_addr != 0 || bus_wr_data != 0 || bus_wr_biten != 0) begin
         errors++;
         $display("FAIL %s got rdy=%b err=%b d=%h req=%b a=%h wd=%h be=%h required all 0",
                  name, pready, pslverr, prdata, bus_req, bus_addr,
                  bus_wr_data, bus_wr_biten);
      end
   endtask

   initial begin
      req_t e;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset_state");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      xfer(1, BASE + 32'h04, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 0, 0,
           1, 32'hFFFFFFFF, 32'h0, 0, 2);
      xfer(1, BASE + 32'h0C, 32'hA5A5A5A5, 4'b0101, 0, 0, 0, 0, 0,
           1, 32'h00FF00FF, 32'h0, 0, 2);
      xfer(1, BASE + 32'h10, 32'h01020304, 4'b0000, 0, 0, -1, 0, 0,
           0, 32'h0, 32'h0, 0, 1);
      xfer(0, BASE + 32'h08, 32'h0, 4'b0000, 0, 0, 3, 32'h12345678, 0,
           1, 32'h0, 32'h12345678, 0, 5);
      xfer(0, BASE + 32'h100, 32'h0, 4'b0000, 0, 0, -1, 0, 0,
           0, 32'h0, 32'h0, 1, 1);
      xfer(1, BASE + 32'h02, 32'h77777777, 4'b1111, 0, 0, -1, 0, 0,
           0, 32'h0, 32'h0, 1, 1);
      xfer(0, BASE + 32'h14, 32'h0, 4'b0000, 4, 0, 0, 32'hCAFEF00D, 0,
           1, 32'h0, 32'hCAFEF00D, 0, 6);
      xfer(1, BASE + 32'h18, 32'h11223344, 4'b1000, 4, 0, 0, 0, 0,
           1, 32'hFF000000, 32'h0, 0, 2);
      xfer(0, BASE + 32'h1C, 32'h0, 4'b0000, 0, 0, 1, 32'h55555555, 1,
           1, 32'h0, 32'h55555555, 1, 3);
      xfer(1, BASE + 32'h20, 32'h89ABCDEF, 4'b0011, 0, 2, 0, 0, 0,
           1, 32'h0000FFFF, 32'h0, 0, 4);

      // stray bus_ready while idle must not leak into the next read
      @(posedge clk); #1;
      bus_ready = 1'b1; bus_rd_data = 32'hFFFFFFFF; bus_err = 1'b1;
      repeat (2) @(posedge clk);
      #1 bus_clr();

      xfer(0, BASE + 32'hFC, 32'h0, 4'b0000, 0, 0, 0, 32'h0F0F0F0F, 0,
           1, 32'h0, 32'h0F0F0F0F, 0, 2);
      xfer(0, BASE - 32'h04, 32'h0, 4'b0000, 0, 0, -1, 0, 0,
           0, 32'h0, 32'h0, 1, 1);
`ifdef APB4_BRIDGE_TIMEOUT_EN
      xfer(0, BASE + 32'h24, 32'h0, 4'b0000, 0, 0, -1, 0, 0,
           1, 32'h0, 32'h0, 1, 17);
`endif

      // reset while waiting on the regblock
      e.wr = 1'b0; e.addr = 8'h28; e.wdata = '0; e.biten = '0;
      req_q.push_back(e);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = BASE + 32'h28;
      repeat (3) begin
         @(posedge clk); #1;
         penable = 1'b1;
      end
      @(negedge clk); #2;
      rst = 1'b1;
      #1 chk_zero("reset_mid_wait");
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; paddr = '0;
      @(negedge clk);
      chk_zero("reset_hold");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("after_reset_idle");

      checks++;
      if (req_q.size() != 0 || rsp_q.size() != 0) begin
         errors++;
         $display("FAIL queues_drained got req=%0d rsp=%0d required 0/0",
                  req_q.size(), rsp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
